// File: rtl/uart_event_reporter_if.sv
// Byte-transmitter handshake between the event reporter and a uart_tx-style sender.
// The reporter drives data and the send strobe; the transmitter answers with busy.
interface uart_event_reporter_if;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy;

  modport master (output tx_data, output tx_send, input tx_busy);
  modport slave  (input tx_data, input tx_send, output tx_busy);
endinterface

// File: rtl/uart_event_reporter.sv
// Formats game-state change events and a periodic heartbeat into ASCII messages,
// queues them in a byte FIFO and drains the FIFO into a byte transmitter.
module uart_event_reporter #(
  parameter int unsigned N_CELLS     = 9,
  parameter int unsigned CELL_W      = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HB_INTERVAL = 50_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CELL_W-1:0]          cur_cell,
  input  logic [N_CELLS-1:0]         cell_flags,
  input  logic                       win_flag,
  uart_event_reporter_if.master      tx,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned IDX_W = 6;
  localparam int unsigned HB_W  = (HB_INTERVAL > 2) ? $clog2(HB_INTERVAL) : 1;
  localparam logic [HB_W-1:0] HB_LAST = (HB_INTERVAL == 0) ? '0 : HB_W'(HB_INTERVAL - 1);

  typedef enum logic [1:0] {B_IDLE, B_CHECK, B_EMIT} bstate_e;
  typedef enum logic [1:0] {D_IDLE, D_GUARD, D_WAIT} dstate_e;
  typedef enum logic [2:0] {M_NONE, M_WIN, M_BOARD, M_CUR, M_HB} msg_e;

  bstate_e             bstate_q, bstate_d;
  msg_e                msg_q, msg_d, sel_msg;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_CELLS-1:0]  snap_flags_q, snap_flags_d;
  logic [CELL_W-1:0]   snap_cell_q, snap_cell_d;
  logic [CELL_W-1:0]   prev_cell_q, prev_cell_d;
  logic [N_CELLS-1:0]  prev_flags_q, prev_flags_d;
  logic                prev_win_q, prev_win_d;
  logic [HB_W-1:0]     hb_cnt_q, hb_cnt_d;
  logic                ovf_q, ovf_d;

  dstate_e             dstate_q, dstate_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_send_q, tx_send_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          mem_q [DEPTH];

  logic                win_chg, flags_chg, cell_chg, hb_due, any_pending;
  logic                wr_en, rd_en;
  logic [7:0]          wr_byte, hex_char;
  logic [3:0]          hex_val;
  logic [N_CELLS-1:0]  flag_sh;
  logic [31:0]         msg_len, free_space;

  assign win_chg     = (win_flag != prev_win_q);
  assign flags_chg   = (cell_flags != prev_flags_q);
  assign cell_chg    = (cur_cell != prev_cell_q);
  assign hb_due      = (HB_INTERVAL != 0) && (hb_cnt_q == HB_LAST);
  assign any_pending = win_chg | flags_chg | cell_chg | hb_due;
  assign free_space  = DEPTH - 32'(level_q);

  // A falling win flag still takes a pass (as M_NONE) so prev_win is resynced without a message.
  always_comb begin
    sel_msg = M_HB;
    if (win_chg)        sel_msg = win_flag ? M_WIN : M_NONE;
    else if (flags_chg) sel_msg = M_BOARD;
    else if (cell_chg)  sel_msg = M_CUR;
  end

  always_comb begin
    case (msg_q)
      M_WIN:       msg_len = 32'd2;
      M_BOARD:     msg_len = N_CELLS + 32'd2;
      M_CUR, M_HB: msg_len = 32'd3;
      default:     msg_len = 32'd0;
    endcase
  end

  assign hex_val  = 4'(snap_cell_q);
  assign hex_char = (hex_val < 4'd10) ? (8'h30 + {4'h0, hex_val}) : (8'h37 + {4'h0, hex_val});
  assign flag_sh  = snap_flags_q >> (idx_q - IDX_W'(1));

  always_comb begin
    wr_byte = 8'h0A;
    case (msg_q)
      M_WIN: if (idx_q == '0) wr_byte = 8'h57;
      M_BOARD: begin
        if (idx_q == '0)                 wr_byte = 8'h42;
        else if (32'(idx_q) <= N_CELLS)  wr_byte = flag_sh[0] ? 8'h31 : 8'h30;
      end
      M_CUR, M_HB: begin
        if (idx_q == '0)                 wr_byte = (msg_q == M_CUR) ? 8'h50 : 8'h48;
        else if (idx_q == IDX_W'(1))     wr_byte = hex_char;
      end
      default: ;
    endcase
  end

  always_comb begin
    bstate_d     = bstate_q;
    msg_d        = msg_q;
    idx_d        = idx_q;
    snap_flags_d = snap_flags_q;
    snap_cell_d  = snap_cell_q;
    prev_cell_d  = prev_cell_q;
    prev_flags_d = prev_flags_q;
    prev_win_d   = prev_win_q;
    hb_cnt_d     = hb_cnt_q;
    ovf_d        = clr_overflow ? 1'b0 : ovf_q;
    wr_en        = 1'b0;
    if (enable && !hb_due) hb_cnt_d = hb_cnt_q + HB_W'(1);
    case (bstate_q)
      B_IDLE: begin
        if (enable && any_pending) begin
          bstate_d     = B_CHECK;
          msg_d        = sel_msg;
          idx_d        = '0;
          snap_flags_d = cell_flags;
          snap_cell_d  = cur_cell;
          if (win_chg)        prev_win_d   = win_flag;
          else if (flags_chg) prev_flags_d = cell_flags;
          else if (cell_chg)  prev_cell_d  = cur_cell;
          if (sel_msg != M_NONE) hb_cnt_d = '0;
        end
      end
      B_CHECK: begin
        if (msg_q == M_NONE) begin
          bstate_d = B_IDLE;
        end else if (free_space >= msg_len) begin
          bstate_d = B_EMIT;
        end else begin
          bstate_d = B_IDLE;
          ovf_d    = 1'b1;
        end
      end
      B_EMIT: begin
        wr_en = 1'b1;
        idx_d = idx_q + IDX_W'(1);
        if (32'(idx_q) == msg_len - 32'd1) bstate_d = B_IDLE;
      end
      default: bstate_d = B_IDLE;
    endcase
  end

  always_comb begin
    dstate_d  = dstate_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    rd_en     = 1'b0;
    case (dstate_q)
      D_IDLE: begin
        if ((level_q != '0) && !tx.tx_busy) begin
          rd_en     = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          dstate_d  = D_GUARD;
        end
      end
      D_GUARD: dstate_d = D_WAIT;
      D_WAIT:  if (!tx.tx_busy) dstate_d = D_IDLE;
      default: dstate_d = D_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    level_d  = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bstate_q     <= B_IDLE;
      msg_q        <= M_NONE;
      idx_q        <= '0;
      snap_flags_q <= '0;
      snap_cell_q  <= '0;
      prev_cell_q  <= '0;
      prev_flags_q <= '0;
      prev_win_q   <= 1'b0;
      hb_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      dstate_q     <= D_IDLE;
      tx_data_q    <= '0;
      tx_send_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      bstate_q     <= bstate_d;
      msg_q        <= msg_d;
      idx_q        <= idx_d;
      snap_flags_q <= snap_flags_d;
      snap_cell_q  <= snap_cell_d;
      prev_cell_q  <= prev_cell_d;
      prev_flags_q <= prev_flags_d;
      prev_win_q   <= prev_win_d;
      hb_cnt_q     <= hb_cnt_d;
      ovf_q        <= ovf_d;
      dstate_q     <= dstate_d;
      tx_data_q    <= tx_data_d;
      tx_send_q    <= tx_send_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  assign tx.tx_data = tx_data_q;
  assign tx.tx_send = tx_send_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_event_reporter.sv
// Directed bench: a main reporter (no heartbeat) and a second one with a 20-cycle heartbeat,
// each driving a simple busy-counter transmitter model that logs every sent byte.
module tb_uart_event_reporter;
  logic       clk = 1'b0;
  logic       reset;
  logic       enable, win_flag, clr_overflow, hold1;
  logic [3:0] cur_cell, hb_cell;
  logic [8:0] cell_flags;
  logic [4:0] fifo_level, hb_level;
  logic       overflow, hb_ovf;

  always #5 clk = ~clk;

  uart_event_reporter_if tx1();
  uart_event_reporter_if tx2();

  uart_event_reporter #(.N_CELLS(9), .CELL_W(4), .DEPTH(16), .HB_INTERVAL(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cur_cell(cur_cell), .cell_flags(cell_flags),
    .win_flag(win_flag), .tx(tx1), .fifo_level(fifo_level), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  uart_event_reporter #(.N_CELLS(9), .CELL_W(4), .DEPTH(16), .HB_INTERVAL(20)) dut_hb (
    .clk(clk), .reset(reset), .enable(1'b1), .cur_cell(hb_cell), .cell_flags(9'h000),
    .win_flag(1'b0), .tx(tx2), .fifo_level(hb_level), .overflow(hb_ovf),
    .clr_overflow(1'b0)
  );

  int         busy1 = 0, busy2 = 0, dbl1 = 0, cyc = 0;
  logic       prev_send1 = 1'b0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         t2[$];
  int         n_checks = 0, n_errors = 0;
  int         base;

  assign tx1.tx_busy = hold1 | (busy1 != 0);
  assign tx2.tx_busy = (busy2 != 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter models: busy for 10 (main) or 1 (heartbeat) cycles after each send strobe.
  always @(negedge clk) begin
    if (reset) begin
      busy1 = 0;
      busy2 = 0;
      prev_send1 = 1'b0;
    end else begin
      if (tx1.tx_send) begin
        q1.push_back(tx1.tx_data);
        busy1 = 10;
      end else if (busy1 != 0) busy1--;
      if (tx1.tx_send && prev_send1) dbl1++;
      prev_send1 = tx1.tx_send;
      if (tx2.tx_send) begin
        q2.push_back(tx2.tx_data);
        t2.push_back(cyc);
        busy2 = 1;
      end else if (busy2 != 0) busy2--;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_q(input bit hb, input int n, input int budget);
    int k = 0;
    while (((hb ? q2.size() : q1.size()) < n) && (k < budget)) begin
      cycles(1);
      k++;
    end
    if ((hb ? q2.size() : q1.size()) < n)
      chk(hb ? "wait_hb_bytes" : "wait_main_bytes", 32'(hb ? q2.size() : q1.size()), 32'(n));
  endtask

  task automatic chk_msg(input bit hb, input string tag, input int b, input string exp);
    logic [7:0] got;
    for (int i = 0; i < exp.len(); i++) begin
      got = 8'h00;
      if (b + i < (hb ? q2.size() : q1.size())) got = hb ? q2[b + i] : q1[b + i];
      chk($sformatf("%s[%0d]", tag, i), {24'h0, got}, {24'h0, exp[i]});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; win_flag = 1'b0; clr_overflow = 1'b0; hold1 = 1'b0;
    cur_cell = 4'd0; hb_cell = 4'd0; cell_flags = 9'h000;
    cycles(3);
    chk("rst_tx_send", 32'(tx1.tx_send), 32'd0);
    chk("rst_tx_data", 32'(tx1.tx_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Heartbeat every 20 cycles; cursor change 15 cycles after the third restarts the interval.
    wait_q(1'b1, 7, 300);
    cycles(15);
    hb_cell = 4'd7;
    wait_q(1'b1, 15, 200);
    chk_msg(1'b1, "hb", 0, "H0\nH0\nH0\nP7\nH7\n");
    chk("hb_period_a", 32'(t2[3] - t2[0]), 32'd20);
    chk("hb_period_b", 32'(t2[6] - t2[3]), 32'd20);
    chk("hb_restart", 32'(t2[12] - t2[9]), 32'd20);

    // Single cursor change.
    base = q1.size();
    cur_cell = 4'd5;
    wait_q(1'b0, base + 3, 200);
    chk_msg(1'b0, "cur5", base, "P5\n");
    cycles(20);
    chk("cur5_level", 32'(fifo_level), 32'd0);

    base = q1.size();
    cur_cell = 4'd3;
    wait_q(1'b0, base + 3, 200);
    chk_msg(1'b0, "cur3", base, "P3\n");
    cycles(20);

    // Simultaneous win, board and cursor events: priority order W, B, P.
    base = q1.size();
    win_flag = 1'b1; cell_flags = 9'h101; cur_cell = 4'd4;
    wait_q(1'b0, base + 16, 600);
    chk_msg(1'b0, "multi", base, "W\nB100000001\nP4\n");
    cycles(20);
    chk("multi_level", 32'(fifo_level), 32'd0);

    // Fill with transmitter stalled, then overflow.
    hold1 = 1'b1;
    cycles(15);
    base = q1.size();
    for (int v = 1; v <= 5; v++) begin
      cur_cell = 4'(v);
      cycles(8);
    end
    chk("fill_level", 32'(fifo_level), 32'd15);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    cur_cell = 4'd6;
    cycles(8);
    chk("drop_level", 32'(fifo_level), 32'd15);
    chk("drop_ovf", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    cycles(1);
    clr_overflow = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    cur_cell = 4'd7;
    cycles(8);
    chk("drop2_ovf", 32'(overflow), 32'd1);
    chk("drop2_level", 32'(fifo_level), 32'd15);
    hold1 = 1'b0;
    wait_q(1'b0, base + 15, 500);
    chk_msg(1'b0, "fill", base, "P1\nP2\nP3\nP4\nP5\n");
    cycles(40);
    chk("no_retry", 32'(q1.size()), 32'(base + 15));
    chk("fill_drained", 32'(fifo_level), 32'd0);

    // Hex digit above 9, silent win fall, enable gating.
    base = q1.size();
    cur_cell = 4'd11;
    wait_q(1'b0, base + 3, 200);
    chk_msg(1'b0, "hexB", base, "PB\n");
    cycles(20);
    win_flag = 1'b0;
    cycles(40);
    chk("win_fall_silent", 32'(q1.size()), 32'(base + 3));
    enable = 1'b0;
    cur_cell = 4'd2;
    cycles(30);
    chk("enable_low", 32'(q1.size()), 32'(base + 3));
    enable = 1'b1;
    wait_q(1'b0, base + 6, 200);
    chk_msg(1'b0, "enable_resume", base + 3, "P2\n");
    cycles(20);

    // Reset in the middle of a board message.
    cell_flags = 9'h0ff;
    cycles(3);
    reset = 1'b1;
    #1;
    chk("emit_rst_send", 32'(tx1.tx_send), 32'd0);
    chk("emit_rst_level", 32'(fifo_level), 32'd0);
    chk("emit_rst_ovf", 32'(overflow), 32'd0);
    cur_cell = 4'd0; cell_flags = 9'h000;
    cycles(2);
    reset = 1'b0;
    cycles(3);
    base = q1.size();
    cur_cell = 4'd9;
    wait_q(1'b0, base + 3, 200);
    chk_msg(1'b0, "post_rst1", base, "P9\n");
    cycles(20);
    chk("post_rst1_level", 32'(fifo_level), 32'd0);

    // Reset while the drain waits on the transmitter.
    base = q1.size();
    cur_cell = 4'd10;
    wait_q(1'b0, base + 1, 100);
    cycles(3);
    reset = 1'b1;
    #1;
    chk("wait_rst_send", 32'(tx1.tx_send), 32'd0);
    chk("wait_rst_level", 32'(fifo_level), 32'd0);
    cur_cell = 4'd0;
    cycles(2);
    reset = 1'b0;
    cycles(3);
    base = q1.size();
    cur_cell = 4'd15;
    wait_q(1'b0, base + 3, 200);
    chk_msg(1'b0, "post_rst2", base, "PF\n");
    cycles(20);
    chk("post_rst2_level", 32'(fifo_level), 32'd0);
    chk("single_pulse", 32'(dbl1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
